// File: rtl/led4_pipe_checker.sv
// Receive-side monitor for the running-light LED pipe.
// Locks onto the rotating one-hot pattern, flags violations, counts laps.
module led4_pipe_checker #(
    parameter int WIDTH       = 4,
    parameter int POS_W       = 2,
    parameter int STEP_CYCLES = 1,
    parameter int LOCK_COUNT  = 4,
    parameter int LAP_W       = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] diode,
    input  logic             clear_err,
    output logic             locked,
    output logic             error,
    output logic             err_sticky,
    output logic [POS_W-1:0] position,
    output logic [LAP_W-1:0] lap_count
);

    localparam int H_W = $clog2(STEP_CYCLES + 1);
    localparam int S_W = $clog2(LOCK_COUNT + 1);

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        LOCKING = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] diode_q;
    logic [WIDTH-1:0] cur_q, cur_d;
    logic [H_W-1:0]   h_q, h_d;
    logic [S_W-1:0]   steps_q, steps_d;
    logic             locked_d, error_d, sticky_d;
    logic [POS_W-1:0] pos_d, pos_idx;
    logic [LAP_W-1:0] lap_d;

    logic             one_hot;
    logic [WIDTH-1:0] rot_cur;
    logic             hold, ok_hold, ok_step, mismatch;

    assign one_hot  = (diode_q != '0) &&
                      ((diode_q & (diode_q - WIDTH'(1))) == '0);
    assign rot_cur  = {cur_q[WIDTH-2:0], cur_q[WIDTH-1]};
    assign hold     = h_q < H_W'(STEP_CYCLES);
    assign ok_hold  = hold && (diode_q == cur_q);
    assign ok_step  = !hold && (diode_q == rot_cur);
    assign mismatch = !(ok_hold || ok_step);

    always_comb begin
        pos_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (diode_q[i]) pos_idx = POS_W'(i);
        end
    end

    always_comb begin
        state_d  = state_q;
        cur_d    = cur_q;
        h_d      = h_q;
        steps_d  = steps_q;
        locked_d = locked;
        error_d  = 1'b0;
        sticky_d = clear_err ? 1'b0 : err_sticky;
        lap_d    = lap_count;
        pos_d    = one_hot ? pos_idx : position;

        unique case (state_q)
            HUNT: begin
                locked_d = 1'b0;
                if (one_hot) begin
                    cur_d   = diode_q;
                    h_d     = H_W'(1);
                    steps_d = '0;
                    state_d = LOCKING;
                end
            end
            LOCKING: begin
                if (mismatch) begin
                    error_d = 1'b1;
                    state_d = HUNT;
                end else if (ok_hold) begin
                    h_d = h_q + H_W'(1);
                end else begin
                    cur_d   = rot_cur;
                    h_d     = H_W'(1);
                    steps_d = steps_q + S_W'(1);
                    if (steps_q == S_W'(LOCK_COUNT - 1)) begin
                        state_d  = LOCKED;
                        locked_d = 1'b1;
                    end
                end
            end
            LOCKED: begin
                if (mismatch) begin
                    error_d  = 1'b1;
                    sticky_d = 1'b1;
                    locked_d = 1'b0;
                    state_d  = HUNT;
                end else if (ok_hold) begin
                    h_d = h_q + H_W'(1);
                end else begin
                    cur_d = rot_cur;
                    h_d   = H_W'(1);
                    // MSB wrapping back to LSB closes one lap
                    if (cur_q[WIDTH-1]) lap_d = lap_count + LAP_W'(1);
                end
            end
            default: begin
                locked_d = 1'b0;
                state_d  = HUNT;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= HUNT;
            diode_q    <= '0;
            cur_q      <= '0;
            h_q        <= '0;
            steps_q    <= '0;
            locked     <= 1'b0;
            error      <= 1'b0;
            err_sticky <= 1'b0;
            position   <= '0;
            lap_count  <= '0;
        end else begin
            state_q    <= state_d;
            diode_q    <= diode;
            cur_q      <= cur_d;
            h_q        <= h_d;
            steps_q    <= steps_d;
            locked     <= locked_d;
            error      <= error_d;
            err_sticky <= sticky_d;
            position   <= pos_d;
            lap_count  <= lap_d;
        end
    end

endmodule
